// File: rtl/hr_inject_if.sv
// Core-to-inject-queue handshake bundle: enqueue side from the core, injection
// side toward the HRnode local port, plus status flags.
interface hr_inject_if #(
    parameter int DEPTH  = 4,
    parameter int FLIT_W = 144
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              enq_i;
    logic [FLIT_W-1:0] enq_flit_i;
    logic              full_o;
    logic [CW-1:0]     count_o;
    logic [FLIT_W-1:0] inj_flit_o;
    logic              inj_ack_i;
    logic              ovf_o;
    logic              starve_o;

    modport slave (
        input  enq_i, enq_flit_i, inj_ack_i,
        output full_o, count_o, inj_flit_o, ovf_o, starve_o
    );

    modport master (
        output enq_i, enq_flit_i, inj_ack_i,
        input  full_o, count_o, inj_flit_o, ovf_o, starve_o
    );
endinterface

// File: rtl/hr_inject_queue.sv
// Circular flit queue between a core and an HRnode local input port, with a
// registered head flit, sticky overflow flag and head-starvation detection.
module hr_inject_queue #(
    parameter int         DEPTH      = 4,
    parameter int         FLIT_W     = 144,
    parameter int         VBIT       = 143,
    parameter logic [7:0] STARVE_LIM = 8'd15
) (
    input  logic       clk,
    input  logic       rst,
    hr_inject_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PW-1:0]     head, tail, head_n, tail_n, head_inc;
    logic [CW-1:0]     count, count_n;
    logic [7:0]        wait_cnt, wait_n;
    logic [FLIT_W-1:0] out_q, out_n, flit_in;
    logic              ovf_q, starve_q, starve_n;
    logic              full, push, pop;

    assign full     = (count == CW'(DEPTH));
    assign head_inc = head + PW'(1);

    always_comb begin
        push     = bus.enq_i && !full;
        pop      = bus.inj_ack_i && (count != '0);
        flit_in  = bus.enq_flit_i;
        flit_in[VBIT] = 1'b1;
        head_n   = pop  ? head_inc : head;
        tail_n   = push ? tail + PW'(1) : tail;
        count_n  = count;
        if (push && !pop)
            count_n = count + CW'(1);
        else if (pop && !push)
            count_n = count - CW'(1);

        // Head register tracks the next head; on a pop from a single entry the
        // same-cycle enqueue is not in storage yet, so forward it directly.
        out_n = out_q;
        if (pop)
            out_n = (count > CW'(1)) ? mem[head_inc] : (push ? flit_in : '0);
        else if (count == '0 && push)
            out_n = flit_in;

        if (pop || count == '0)
            wait_n = '0;
        else if (wait_cnt == 8'hff)
            wait_n = wait_cnt;
        else
            wait_n = wait_cnt + 8'd1;

        starve_n = (count_n != '0) && (wait_n >= STARVE_LIM);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            wait_cnt <= '0;
            out_q    <= '0;
            ovf_q    <= 1'b0;
            starve_q <= 1'b0;
        end else begin
            head     <= head_n;
            tail     <= tail_n;
            count    <= count_n;
            wait_cnt <= wait_n;
            out_q    <= out_n;
            starve_q <= starve_n;
            if (bus.enq_i && full)
                ovf_q <= 1'b1;
        end
    end

    // Storage is left uncleared on reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push)
            mem[tail] <= flit_in;
    end

    assign bus.full_o     = full;
    assign bus.count_o    = count;
    assign bus.inj_flit_o = out_q;
    assign bus.ovf_o      = ovf_q;
    assign bus.starve_o   = starve_q;
endmodule
